// File: rtl/cgol_gen_engine.sv
// cgol_gen_engine: generation sequencer for an 8x8 toroidal Game-of-Life board.
// Walks rows 0..7 through an external row decoder, gathers the results in a
// shadow buffer, then commits the whole generation in one edge so the display
// port only ever sees complete frames.
// Optional feature macro: CGOL_STABLE_DETECT_EN (builds the "board unchanged"
// comparator that drives `stable`; without it `stable` is tied low).
module cgol_gen_engine #(
  parameter int GEN_W = 16
) (
  input  logic             ph1,
  input  logic             ph2,
  input  logic             reset_n,
  input  logic             load_valid,
  input  logic [2:0]       load_addr,
  input  logic [7:0]       load_data,
  output logic             load_ready,
  input  logic             step,
  output logic             busy,
  output logic             done,
  output logic [7:0]       row_in,
  output logic [7:0]       row_a,
  output logic [7:0]       row_b,
  input  logic [7:0]       row_out,
  input  logic [2:0]       disp_addr,
  output logic [7:0]       disp_row,
  output logic [GEN_W-1:0] gen_count,
  output logic             stable
);

  typedef enum logic [1:0] {IDLE, COMPUTE, COMMIT} state_t;

  state_t                state_q, state_d;
  logic [7:0][7:0]       board_q, board_d;
  logic [7:0][7:0]       nxt_q, nxt_d;
  logic [2:0]            idx_q, idx_d;
  logic [GEN_W-1:0]      gen_q, gen_d;
  logic                  done_q, done_d;
  logic [2:0]            idx_up, idx_dn;

  // ph2 belongs to the two-phase clock pair but this block runs on ph1 only
  logic unused_ph2;
  assign unused_ph2 = ph2;

  // wrapped neighbour rows; 3-bit arithmetic gives the torus wrap for free
  assign idx_up = idx_q - 3'd1;
  assign idx_dn = idx_q + 3'd1;

  assign row_in     = board_q[idx_q];
  assign row_a      = board_q[idx_up];
  assign row_b      = board_q[idx_dn];
  assign disp_row   = board_q[disp_addr];
  assign load_ready = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign gen_count  = gen_q;

`ifdef CGOL_STABLE_DETECT_EN
  logic stable_q, stable_d;
  assign stable = stable_q;
`else
  assign stable = 1'b0;
`endif

  // next-state: load/step arbitration, row walk, and whole-board commit
  always_comb begin
    state_d = state_q;
    board_d = board_q;
    nxt_d   = nxt_q;
    idx_d   = idx_q;
    gen_d   = gen_q;
    done_d  = 1'b0;
`ifdef CGOL_STABLE_DETECT_EN
    stable_d = stable_q;
`endif
    case (state_q)
      IDLE: begin
        // a load always beats a simultaneous step; the step is not remembered
        if (load_valid) begin
          board_d[load_addr] = load_data;
          gen_d              = '0;
`ifdef CGOL_STABLE_DETECT_EN
          stable_d           = 1'b0;
`endif
        end else if (step) begin
          state_d = COMPUTE;
          idx_d   = 3'd0;
        end
      end
      COMPUTE: begin
        nxt_d[idx_q] = row_out;
        idx_d        = idx_q + 3'd1;  // wraps to 0 after row 7
        if (idx_q == 3'd7) state_d = COMMIT;
      end
      COMMIT: begin
        board_d = nxt_q;
        gen_d   = gen_q + GEN_W'(1);
        done_d  = 1'b1;
`ifdef CGOL_STABLE_DETECT_EN
        stable_d = (nxt_q == board_q);
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // state register; reset discards any partial generation and clears the board
  always_ff @(posedge ph1 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      board_q <= '0;
      nxt_q   <= '0;
      idx_q   <= 3'd0;
      gen_q   <= '0;
      done_q  <= 1'b0;
`ifdef CGOL_STABLE_DETECT_EN
      stable_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      board_q <= board_d;
      nxt_q   <= nxt_d;
      idx_q   <= idx_d;
      gen_q   <= gen_d;
      done_q  <= done_d;
`ifdef CGOL_STABLE_DETECT_EN
      stable_q <= stable_d;
`endif
    end
  end

endmodule

// File: tb/tb_cgol_gen_engine.sv
// Self-checking bench for cgol_gen_engine: table vectors, random boards
// against a whole-board life model, and hand-written handshake/reset cases.
module tb_cgol_gen_engine;

`ifdef CGOL_STABLE_DETECT_EN
  localparam bit STAB_EN = 1'b1;
`else
  localparam bit STAB_EN = 1'b0;
`endif

  logic        ph1 = 1'b0, ph2 = 1'b1, reset_n = 1'b0;
  logic        load_valid = 1'b0, step = 1'b0;
  logic [2:0]  load_addr = '0, disp_addr = '0;
  logic [7:0]  load_data = '0;
  logic        load_ready, busy, done, stable;
  logic [7:0]  row_in, row_a, row_b, row_out, disp_row;
  logic [15:0] gen_count;

  // second instance with a 2-bit counter for the wrap case
  logic        step2 = 1'b0;
  logic        load_ready2, busy2, done2, stable2;
  logic [7:0]  row_in2, row_a2, row_b2, row_out2, disp_row2;
  logic [1:0]  gen_count2;

  int n_tests = 0, n_fail = 0;

  always #5 ph1 = ~ph1;
  always #5 ph2 = ~ph2;

  // one-row decoder: three stacked rows, wrapped columns, standard life rule
  function automatic logic [7:0] dec(input logic [7:0] a, input logic [7:0] m, input logic [7:0] b);
    logic [7:0] r;
    logic [7:0] rows [3];
    r = '0;
    rows[0] = a; rows[1] = m; rows[2] = b;
    for (int c = 0; c < 8; c++) begin
      int n;
      n = 0;
      for (int i = 0; i < 3; i++)
        for (int dc = -1; dc <= 1; dc++)
          if (!(i == 1 && dc == 0)) n += int'(rows[i][(c + dc + 8) % 8]);
      r[c] = (n == 3) || (m[c] && n == 2);
    end
    return r;
  endfunction

  // whole-board reference: bit r*8+c is row r, column c
  function automatic logic [63:0] life(input logic [63:0] b);
    logic [63:0] nb;
    nb = '0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        int n;
        n = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            if (dr != 0 || dc != 0) n += int'(b[((r + dr + 8) % 8) * 8 + (c + dc + 8) % 8]);
        nb[r*8 + c] = (n == 3) || (b[r*8 + c] && n == 2);
      end
    return nb;
  endfunction

  assign row_out  = dec(row_a, row_in, row_b);
  assign row_out2 = dec(row_a2, row_in2, row_b2);

  cgol_gen_engine #(.GEN_W(16)) u_dut (
    .ph1(ph1), .ph2(ph2), .reset_n(reset_n),
    .load_valid(load_valid), .load_addr(load_addr), .load_data(load_data),
    .load_ready(load_ready), .step(step), .busy(busy), .done(done),
    .row_in(row_in), .row_a(row_a), .row_b(row_b), .row_out(row_out),
    .disp_addr(disp_addr), .disp_row(disp_row), .gen_count(gen_count), .stable(stable)
  );

  cgol_gen_engine #(.GEN_W(2)) u_dut2 (
    .ph1(ph1), .ph2(ph2), .reset_n(reset_n),
    .load_valid(1'b0), .load_addr(3'd0), .load_data(8'd0),
    .load_ready(load_ready2), .step(step2), .busy(busy2), .done(done2),
    .row_in(row_in2), .row_a(row_a2), .row_b(row_b2), .row_out(row_out2),
    .disp_addr(3'd0), .disp_row(disp_row2), .gen_count(gen_count2), .stable(stable2)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge ph1);
    #1;
  endtask

  // reads all 8 rows within one clock period (called 1ns after an edge)
  task automatic read_board(output logic [63:0] b);
    for (int r = 0; r < 8; r++) begin
      disp_addr = 3'(r);
      #1;
      b[r*8 +: 8] = disp_row;
    end
  endtask

  task automatic load_board(input logic [63:0] b);
    for (int r = 0; r < 8; r++) begin
      load_valid = 1'b1;
      load_addr  = 3'(r);
      load_data  = b[r*8 +: 8];
      tick();
    end
    load_valid = 1'b0;
  endtask

  // one step; poke>0 re-raises step for one cycle at that latency count
  task automatic run_step(input string nm, input int poke);
    int lat, busy_bad;
    step = 1'b1;
    tick();
    step = 1'b0;
    lat = 1;
    busy_bad = 0;
    while (!done && lat < 30) begin
      if (!busy) busy_bad++;
      step = (lat == poke);
      tick();
      lat++;
    end
    step = 1'b0;
    check({nm, " latency"}, 64'(lat), 64'd10);
    check({nm, " busy during gen"}, 64'(busy_bad), 64'd0);
    check({nm, " busy at done"}, 64'(busy), 64'd0);
    tick();
    check({nm, " done pulse width"}, 64'(done), 64'd0);
  endtask

  typedef struct {
    string       name;
    logic [63:0] init;
    int          steps;
    logic [63:0] exp;
    logic        stab;
  } vec_t;

  initial begin
    vec_t        vecs [6];
    logic [63:0] b, rb, ref_b;
    int          nd, t0, t1, cyc;

    vecs[0] = '{"blinker1",  64'h00000000_1C000000, 1, 64'h00000008_08080000, 1'b0};
    vecs[1] = '{"blinker2",  64'h00000000_1C000000, 2, 64'h00000000_1C000000, 1'b0};
    vecs[2] = '{"wrap rows", 64'h00000000_00000007, 1, 64'h02000000_00000202, 1'b0};
    vecs[3] = '{"wrap cols", 64'h00000000_83000000, 1, 64'h00000001_01010000, 1'b0};
    vecs[4] = '{"empty",     64'h00000000_00000000, 1, 64'h00000000_00000000, 1'b1};
    vecs[5] = '{"block",     64'h00000018_18000000, 1, 64'h00000018_18000000, 1'b1};

    // reset state
    tick(); tick();
    check("rst busy", 64'(busy), 64'd0);
    check("rst load_ready", 64'(load_ready), 64'd1);
    check("rst done", 64'(done), 64'd0);
    check("rst gen", 64'(gen_count), 64'd0);
    check("rst stable", 64'(stable), 64'd0);
    read_board(rb);
    check("rst board", rb, 64'd0);
    reset_n = 1'b1;
    tick();

    // table vectors
    foreach (vecs[i]) begin
      load_board(vecs[i].init);
      check({vecs[i].name, " gen after load"}, 64'(gen_count), 64'd0);
      for (int s = 0; s < vecs[i].steps; s++) run_step(vecs[i].name, 0);
      read_board(rb);
      check({vecs[i].name, " board"}, rb, vecs[i].exp);
      check({vecs[i].name, " gen"}, 64'(gen_count), 64'(vecs[i].steps));
      check({vecs[i].name, " stable"}, 64'(stable), 64'(STAB_EN & vecs[i].stab));
    end

    // a load after the stable block commit clears stable and the counter
    load_valid = 1'b1; load_addr = 3'd0; load_data = 8'h00;
    tick();
    load_valid = 1'b0;
    check("load clears stable", 64'(stable), 64'd0);
    check("load clears gen", 64'(gen_count), 64'd0);

    // load and step together: load wins, no generation starts
    disp_addr = 3'd5;
    load_valid = 1'b1; step = 1'b1; load_addr = 3'd5; load_data = 8'hA5;
    tick();
    load_valid = 1'b0; step = 1'b0;
    check("load+step busy", 64'(busy), 64'd0);
    check("load+step row", 64'(disp_row), 64'hA5);
    nd = 0;
    for (int k = 0; k < 12; k++) begin
      if (done || busy) nd++;
      tick();
    end
    check("load+step dropped", 64'(nd), 64'd0);

    // step pulsed mid-COMPUTE is ignored: one done only
    load_board(64'h00000000_1C000000);
    run_step("poke", 4);
    nd = 0;
    for (int k = 0; k < 15; k++) begin
      if (done || busy) nd++;
      tick();
    end
    check("poke extra activity", 64'(nd), 64'd0);
    read_board(rb);
    check("poke board", rb, 64'h00000008_08080000);
    check("poke gen", 64'(gen_count), 64'd1);

    // random boards against the whole-board model
    for (int i = 0; i < 12; i++) begin
      b = {$urandom, $urandom};
      load_board(b);
      ref_b = life(b);
      run_step("rand", 0);
      read_board(rb);
      check("rand board", rb, ref_b);
      check("rand stable", 64'(stable), 64'(STAB_EN & (ref_b == b)));
    end

    // step held high: back-to-back generations every 10 cycles
    b = {$urandom, $urandom};
    load_board(b);
    step = 1'b1;
    t0 = -1; t1 = -1; cyc = 0;
    while (t1 < 0 && cyc < 40) begin
      tick();
      cyc++;
      if (done) begin
        if (t0 < 0) t0 = cyc; else t1 = cyc;
      end
    end
    step = 1'b0;
    check("throughput spacing", 64'(t1 - t0), 64'd10);
    read_board(rb);
    check("throughput board", rb, life(life(b)));
    check("throughput gen", 64'(gen_count), 64'd2);

    // reset at COMPUTE idx 4 discards everything
    load_board(64'h00000000_1C000000);
    step = 1'b1;
    tick();
    step = 1'b0;
    tick(); tick(); tick(); tick();
    check("pre-reset busy", 64'(busy), 64'd1);
    reset_n = 1'b0;
    #1;
    check("reset busy", 64'(busy), 64'd0);
    check("reset load_ready", 64'(load_ready), 64'd1);
    check("reset gen", 64'(gen_count), 64'd0);
    read_board(rb);
    check("reset board", rb, 64'd0);
    tick();
    reset_n = 1'b1;
    nd = 0;
    for (int k = 0; k < 20; k++) begin
      if (done || busy) nd++;
      tick();
    end
    check("post-reset activity", 64'(nd), 64'd0);
    read_board(rb);
    check("post-reset board", rb, 64'd0);

    // 2-bit counter wraps 3 -> 0
    for (int k = 1; k <= 4; k++) begin
      step2 = 1'b1;
      tick();
      step2 = 1'b0;
      cyc = 0;
      while (!done2 && cyc < 30) begin
        tick();
        cyc++;
      end
      check("gen2 done seen", 64'(done2), 64'd1);
      check("gen2 count", 64'(gen_count2), 64'(k % 4));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
